div_unit: RTL

//   Multicycle radix-2 restoring divider for DIV/DIVU. Sits directly upstream of the HI/LO
//   32-bit registers: quotient feeds LO, remainder feeds HI, and the one-cycle done pulse

---
 rtl/div_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multicycle radix-2 restoring divider for DIV/DIVU, feeding HI (remainder) and LO (quotient).
// Operands are captured on start; results are held until the next op completes.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic             negq;
    logic             negr;
    logic             zero;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_sub;
    logic             take;
    logic             last;

    // Magnitudes of the operands; 0x80000000 negates to itself, which is the
    // correct unsigned magnitude, so the overflow case needs no special handling.
    always_comb begin
        dividend_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_mag  = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    // One restoring step: the compare is a full WIDTH+1 bits, while the
    // subtraction only needs WIDTH bits because the difference is below dvs.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        take    = (shifted >= {1'b0, dvs});
        rem_sub = shifted[WIDTH-1:0] - dvs;
        last    = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Working registers advance with the state; the visible results are only
    // written on the FIX cycle so they hold through ignored starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            negq      <= 1'b0;
            negr      <= 1'b0;
            zero      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo   <= dividend_mag;
                        rem   <= '0;
                        dvs   <= divisor_mag;
                        negq  <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        negr  <= sign & dividend[WIDTH-1];
                        zero  <= (divisor == '0);
                        count <= '0;
                    end
                end
                CALC: begin
                    rem   <= take ? rem_sub : shifted[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], take};
                    count <= count + CW'(1);
                end
                FIX: begin
                    quotient  <= negq ? -quo : quo;
                    remainder <= negr ? -rem : rem;
                    div_zero  <= zero;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
